// File: rtl/ysyx_22040759_lsu_stage.sv
// ysyx_22040759_lsu_stage: EX->WB memory stage with a multi-cycle data request/response port.
// Optional misaligned-access trap enabled by defining YSYX_22040759_LSU_MISALIGN_EN.
module ysyx_22040759_lsu_stage #(
   parameter int XLEN   = 64,
   parameter int PC_W   = 64,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              es_to_ms_valid,
   output logic              ms_allowin,
   input  logic [PC_W-1:0]   es_pc,
   input  logic [INST_W-1:0] es_inst,
   input  logic [XLEN-1:0]   es_alu_result,
   input  logic [XLEN-1:0]   es_src2,
   input  logic [2:0]        es_func3,
   input  logic              es_mem_ren,
   input  logic              es_mem_wen,
   input  logic [4:0]        es_rd,
   input  logic              es_reg_wen,
   input  logic [1:0]        es_wreg_sel,
   output logic              dreq_valid,
   input  logic              dreq_ready,
   output logic              dreq_wen,
   output logic [XLEN-1:0]   dreq_addr,
   output logic [XLEN-1:0]   dreq_wdata,
   output logic [XLEN/8-1:0] dreq_wstrb,
   output logic [1:0]        dreq_size,
   input  logic              drsp_valid,
   input  logic [XLEN-1:0]   drsp_rdata,
   input  logic              ws_allowin,
   output logic              ms_to_ws_valid,
   output logic [PC_W-1:0]   ms_pc,
   output logic [INST_W-1:0] ms_inst,
   output logic              ms_reg_wen,
   output logic [4:0]        ms_rd,
   output logic [1:0]        ms_wreg_sel,
   output logic [XLEN-1:0]   ms_alu_result,
   output logic [XLEN-1:0]   ms_rdata,
   output logic              ms_excp
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

   // On a 32-bit datapath doubleword sizes collapse to word.
   function automatic logic [1:0] f_size(input logic [2:0] f3);
      if (XLEN == 32 && f3[1:0] == 2'd3) return 2'd2;
      else return f3[1:0];
   endfunction

   function automatic logic [OFF_W-1:0] f_low_mask(input logic [1:0] sz);
      logic [3:0] m;
      m = (4'd1 << sz) - 4'd1;
      return m[OFF_W-1:0];
   endfunction

   function automatic logic [NB-1:0] f_strb(input logic [1:0] sz);
      logic [7:0] m;
      case (sz)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m[NB-1:0];
   endfunction

   function automatic logic [XLEN-1:0] f_ext(input logic [XLEN-1:0] d, input logic [2:0] f3);
      case (f3)
         3'b000:  return XLEN'($signed(d[7:0]));
         3'b001:  return XLEN'($signed(d[15:0]));
         3'b010:  return XLEN'($signed(d[31:0]));
         3'b100:  return XLEN'(d[7:0]);
         3'b101:  return XLEN'(d[15:0]);
         3'b110:  return XLEN'(d[31:0]);
         default: return d;
      endcase
   endfunction

   state_t              r_state, w_state_nxt;
   logic                r_valid, r_ren, r_wen, r_reg_wen;
   logic [PC_W-1:0]     r_pc;
   logic [INST_W-1:0]   r_inst;
   logic [XLEN-1:0]     r_alu, r_src2, r_rdata;
   logic [2:0]          r_func3;
   logic [4:0]          r_rd;
   logic [1:0]          r_wreg_sel;
   logic                w_ready_go, w_capture, w_es_mem, w_go_mem, w_es_misalign, w_rsp_take;
   logic [1:0]          w_size;
   logic [OFF_W-1:0]    w_off;
   logic [XLEN-1:0]     w_rshift;

   assign w_ready_go = (r_state == S_IDLE) || (r_state == S_DONE);
   assign ms_allowin = !r_valid || (w_ready_go && ws_allowin);
   assign w_capture  = es_to_ms_valid && ms_allowin;
   assign w_es_mem   = es_mem_ren || es_mem_wen;
   assign w_go_mem   = w_capture && w_es_mem;
   assign w_rsp_take = drsp_valid && (((r_state == S_REQ) && dreq_ready) || (r_state == S_WAIT));

`ifdef YSYX_22040759_LSU_MISALIGN_EN
   logic [1:0] w_es_size;
   logic       r_excp;
   assign w_es_size     = f_size(es_func3);
   assign w_es_misalign = w_es_mem && ((es_alu_result[OFF_W-1:0] & f_low_mask(w_es_size)) != '0);
   assign ms_excp       = r_excp;

   // Misalignment flag follows the captured instruction.
   always_ff @(posedge clk) begin
      if (rst) r_excp <= 1'b0;
      else if (w_capture) r_excp <= w_es_misalign;
   end
`else
   assign w_es_misalign = 1'b0;
   assign ms_excp       = 1'b0;
`endif

   // Sub-size address bits are dropped so the access is aligned down to its natural size.
   assign w_size   = f_size(r_func3);
   assign w_off    = r_alu[OFF_W-1:0] & ~f_low_mask(w_size);
   assign w_rshift = drsp_rdata >> {w_off, 3'b000};

   assign dreq_valid = (r_state == S_REQ);
   assign dreq_wen   = r_wen;
   assign dreq_addr  = {r_alu[XLEN-1:OFF_W], {OFF_W{1'b0}}};
   assign dreq_wdata = r_src2 << {w_off, 3'b000};
   assign dreq_wstrb = r_wen ? (f_strb(w_size) << w_off) : '0;
   assign dreq_size  = w_size;

   assign ms_to_ws_valid = r_valid && w_ready_go;
   assign ms_pc          = r_pc;
   assign ms_inst        = r_inst;
   assign ms_reg_wen     = r_reg_wen;
   assign ms_rd          = r_rd;
   assign ms_wreg_sel    = r_wreg_sel;
   assign ms_alu_result  = r_alu;
   assign ms_rdata       = r_rdata;

   // Next-state logic for the memory access sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_go_mem) w_state_nxt = w_es_misalign ? S_DONE : S_REQ;
            else          w_state_nxt = S_IDLE;
         end
         S_REQ: begin
            if (dreq_ready) w_state_nxt = drsp_valid ? S_DONE : S_WAIT;
            else            w_state_nxt = S_REQ;
         end
         S_WAIT: begin
            if (drsp_valid) w_state_nxt = S_DONE;
            else            w_state_nxt = S_WAIT;
         end
         S_DONE: begin
            if (!ws_allowin)   w_state_nxt = S_DONE;
            else if (w_go_mem) w_state_nxt = w_es_misalign ? S_DONE : S_REQ;
            else               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, valid bit and load result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (ms_allowin) r_valid <= es_to_ms_valid;
         if (w_capture) r_rdata <= '0;
         else if (w_rsp_take && r_ren) r_rdata <= f_ext(w_rshift, r_func3);
      end
   end

   // Payload is left unreset; r_valid qualifies it.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_pc       <= es_pc;
         r_inst     <= es_inst;
         r_alu      <= es_alu_result;
         r_src2     <= es_src2;
         r_func3    <= es_func3;
         r_ren      <= es_mem_ren;
         r_wen      <= es_mem_wen;
         r_rd       <= es_rd;
         r_reg_wen  <= es_reg_wen;
         r_wreg_sel <= es_wreg_sel;
      end
   end
endmodule

// File: tb/tb_ysyx_22040759_lsu_stage.sv
// Self-checking bench for ysyx_22040759_lsu_stage: directed and randomized accesses against a byte-level model.
module tb_ysyx_22040759_lsu_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        es_to_ms_valid, ms_allowin;
   logic [63:0] es_pc, es_alu_result, es_src2;
   logic [31:0] es_inst;
   logic [2:0]  es_func3;
   logic        es_mem_ren, es_mem_wen, es_reg_wen;
   logic [4:0]  es_rd;
   logic [1:0]  es_wreg_sel;
   logic        dreq_valid, dreq_ready, dreq_wen;
   logic [63:0] dreq_addr, dreq_wdata;
   logic [7:0]  dreq_wstrb;
   logic [1:0]  dreq_size;
   logic        drsp_valid;
   logic [63:0] drsp_rdata;
   logic        ws_allowin, ms_to_ws_valid;
   logic [63:0] ms_pc, ms_alu_result, ms_rdata;
   logic [31:0] ms_inst;
   logic        ms_reg_wen, ms_excp;
   logic [4:0]  ms_rd;
   logic [1:0]  ms_wreg_sel;

   int n_cmp = 0;
   int n_err = 0;

   // expected transaction, filled in by the model when an instruction is presented
   logic [63:0] exp_pc, exp_alu, exp_addr, exp_wdata, exp_rdata, cur_rsp;
   logic [31:0] exp_inst;
   logic [4:0]  exp_rd;
   logic [1:0]  exp_sel, exp_size;
   logic [7:0]  exp_wstrb;
   logic        exp_regwen, exp_mem, exp_wen, exp_mis;
   logic [63:0] done_rdata;

   ysyx_22040759_lsu_stage dut (
      .clk(clk), .rst(rst), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
      .es_pc(es_pc), .es_inst(es_inst), .es_alu_result(es_alu_result), .es_src2(es_src2),
      .es_func3(es_func3), .es_mem_ren(es_mem_ren), .es_mem_wen(es_mem_wen), .es_rd(es_rd),
      .es_reg_wen(es_reg_wen), .es_wreg_sel(es_wreg_sel), .dreq_valid(dreq_valid),
      .dreq_ready(dreq_ready), .dreq_wen(dreq_wen), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
      .dreq_wstrb(dreq_wstrb), .dreq_size(dreq_size), .drsp_valid(drsp_valid),
      .drsp_rdata(drsp_rdata), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
      .ms_pc(ms_pc), .ms_inst(ms_inst), .ms_reg_wen(ms_reg_wen), .ms_rd(ms_rd),
      .ms_wreg_sel(ms_wreg_sel), .ms_alu_result(ms_alu_result), .ms_rdata(ms_rdata), .ms_excp(ms_excp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction on the EX side and compute what the stage must produce for it.
   task automatic set_es(input int kind, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] src2, input logic [63:0] rsp);
      longint unsigned nb, off, mask, v;
      es_pc = {$urandom, $urandom};
      es_inst = $urandom;
      es_rd = 5'($urandom);
      es_reg_wen = 1'($urandom);
      es_wreg_sel = 2'($urandom);
      es_alu_result = addr;
      es_src2 = src2;
      es_func3 = f3;
      es_mem_ren = (kind == 1);
      es_mem_wen = (kind == 2);
      es_to_ms_valid = 1'b1;
      exp_pc = es_pc; exp_inst = es_inst; exp_rd = es_rd; exp_regwen = es_reg_wen;
      exp_sel = es_wreg_sel; exp_alu = addr; exp_mem = (kind != 0); exp_wen = (kind == 2);
      cur_rsp = rsp;
      nb = 64'd1 << f3[1:0];
      off = addr % 8;
      exp_mis = 1'b0;
`ifdef YSYX_22040759_LSU_MISALIGN_EN
      exp_mis = exp_mem && ((off % nb) != 0);
`endif
      off = off - (off % nb);
      exp_addr = addr - (addr % 8);
      exp_size = f3[1:0];
      mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
      v = (rsp >> (8 * off)) & mask;
      if (f3[2] == 1'b0 && nb < 8 && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v | ~mask;
      exp_rdata = (kind == 1 && !exp_mis) ? v : 64'd0;
      exp_wdata = src2 << (8 * off);
      exp_wstrb = (kind == 2) ? 8'(((64'd1 << nb) - 64'd1) << off) : 8'h00;
   endtask

   // Play the memory side with the given delays, then check the stage result.
   task automatic mem_phase(input int rdy_dly, input int rsp_dly);
      if (exp_mem && !exp_mis) begin
         for (int i = 0; i <= rdy_dly; i++) begin
            chk("req_valid", dreq_valid, 1'b1);
            chk("req_addr", dreq_addr, exp_addr);
            chk("req_size", dreq_size, exp_size);
            chk("req_wen", dreq_wen, exp_wen);
            chk("req_wstrb", dreq_wstrb, exp_wstrb);
            if (exp_wen) chk("req_wdata", dreq_wdata, exp_wdata);
            chk("req_towsv", ms_to_ws_valid, 1'b0);
            chk("req_allowin", ms_allowin, 1'b0);
            if (i == rdy_dly) begin
               dreq_ready = 1'b1;
               if (rsp_dly == 0) begin drsp_valid = 1'b1; drsp_rdata = cur_rsp; end
            end
            tick();
            dreq_ready = 1'b0; drsp_valid = 1'b0; drsp_rdata = {$urandom, $urandom};
         end
         for (int j = 1; j <= rsp_dly; j++) begin
            chk("wait_reqv", dreq_valid, 1'b0);
            chk("wait_towsv", ms_to_ws_valid, 1'b0);
            chk("wait_allowin", ms_allowin, 1'b0);
            if (j == rsp_dly) begin drsp_valid = 1'b1; drsp_rdata = cur_rsp; end
            tick();
            drsp_valid = 1'b0; drsp_rdata = {$urandom, $urandom};
         end
      end
      chk("done_towsv", ms_to_ws_valid, 1'b1);
      chk("done_reqv", dreq_valid, 1'b0);
      chk("done_pc", ms_pc, exp_pc);
      chk("done_inst", ms_inst, exp_inst);
      chk("done_rd", ms_rd, exp_rd);
      chk("done_regwen", ms_reg_wen, exp_regwen);
      chk("done_sel", ms_wreg_sel, exp_sel);
      chk("done_alu", ms_alu_result, exp_alu);
      chk("done_rdata", ms_rdata, exp_rdata);
      chk("done_excp", ms_excp, exp_mis);
      done_rdata = ms_rdata;
   endtask

   // Hold WB off for some cycles, then open it.
   task automatic drain(input int stall);
      ws_allowin = 1'b0;
      for (int k = 0; k < stall; k++) begin
         #1;
         chk("stall_towsv", ms_to_ws_valid, 1'b1);
         chk("stall_rdata", ms_rdata, exp_rdata);
         chk("stall_alu", ms_alu_result, exp_alu);
         chk("stall_allowin", ms_allowin, 1'b0);
         chk("stall_reqv", dreq_valid, 1'b0);
         tick();
      end
      ws_allowin = 1'b1;
      #1;
      chk("handoff_allowin", ms_allowin, 1'b1);
   endtask

   task automatic run(input int rdy_dly, input int rsp_dly, input int stall);
      chk("pre_allowin", ms_allowin, 1'b1);
      tick();
      es_to_ms_valid = 1'b0;
      ws_allowin = 1'b0;
      mem_phase(rdy_dly, rsp_dly);
      drain(stall);
      tick();
      chk("empty_towsv", ms_to_ws_valid, 1'b0);
      ws_allowin = 1'b0;
   endtask

   initial begin
      rst = 1'b1; es_to_ms_valid = 1'b0; dreq_ready = 1'b0; drsp_valid = 1'b0;
      drsp_rdata = 64'd0; ws_allowin = 1'b0;
      set_es(0, 3'b000, 64'd0, 64'd0, 64'd0);
      es_to_ms_valid = 1'b0;
      repeat (2) tick();
      chk("rst_towsv", ms_to_ws_valid, 1'b0);
      chk("rst_reqv", dreq_valid, 1'b0);
      chk("rst_allowin", ms_allowin, 1'b1);
      chk("rst_rdata", ms_rdata, 64'd0);
      chk("rst_excp", ms_excp, 1'b0);
      rst = 1'b0;

      // non-memory instruction passes through in one cycle
      set_es(0, 3'b000, 64'h1234, 64'd7, 64'd0);
      run(0, 0, 0);
      // lb / lbu of byte 3 = 0x80
      set_es(1, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000);
      run(0, 0, 1);
      chk("lb_lit", done_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      set_es(1, 3'b100, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000);
      run(0, 0, 0);
      chk("lbu_lit", done_rdata, 64'h0000_0000_0000_0080);
      // sh at offset 6
      set_es(2, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_BEEF, {$urandom, $urandom});
      run(1, 1, 0);
      // slow memory: ready after 3 cycles, response 2 later
      set_es(1, 3'b011, 64'h8000_0010, 64'd0, {$urandom, $urandom});
      run(3, 2, 0);

      // DONE stalled 4 cycles, then back-to-back load captured at the handoff
      set_es(1, 3'b010, 64'h8000_0024, 64'd0, {$urandom, $urandom});
      chk("b2b_pre_allowin", ms_allowin, 1'b1);
      tick();
      es_to_ms_valid = 1'b0;
      mem_phase(0, 1);
      drain(4);
      set_es(1, 3'b101, 64'h8000_0042, 64'd0, {$urandom, $urandom});
      tick();
      es_to_ms_valid = 1'b0;
      ws_allowin = 1'b0;
      mem_phase(1, 0);
      drain(0);
      tick();
      chk("b2b_empty", ms_to_ws_valid, 1'b0);

      // randomized mix
      for (int n = 0; n < 40; n++) begin
         int kind;
         logic [2:0] f3;
         kind = $urandom_range(0, 2);
         f3 = (kind == 0) ? 3'($urandom) : ((kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6)));
         set_es(kind, f3, 64'h8000_0000 + 64'($urandom_range(0, 255)), {$urandom, $urandom}, {$urandom, $urandom});
         run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      // reset while waiting for the response
      set_es(1, 3'b011, 64'h8000_0080, 64'd0, {$urandom, $urandom});
      tick();
      es_to_ms_valid = 1'b0;
      chk("mrst_req", dreq_valid, 1'b1);
      dreq_ready = 1'b1;
      tick();
      dreq_ready = 1'b0;
      chk("mrst_wait", dreq_valid, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_reqv", dreq_valid, 1'b0);
      chk("mrst_towsv", ms_to_ws_valid, 1'b0);
      chk("mrst_allowin", ms_allowin, 1'b1);
      drsp_valid = 1'b1; drsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      drsp_valid = 1'b0;
      chk("late_towsv", ms_to_ws_valid, 1'b0);
      chk("late_reqv", dreq_valid, 1'b0);
      chk("late_rdata", ms_rdata, 64'd0);
      set_es(1, 3'b000, 64'h8000_0101, 64'd0, {$urandom, $urandom});
      run(0, 0, 0);

`ifdef YSYX_22040759_LSU_MISALIGN_EN
      set_es(1, 3'b010, 64'h8000_0002, 64'd0, {$urandom, $urandom});
      run(0, 0, 0);
      chk("mis_rdata", done_rdata, 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
